bitos_data_mem: RTL and testbench

- Data-side memory stage directly downstream of the MicroBitos core.
- Consumes the core's data address bus, write data bus and W_R strobe, and returns read data to the core's data input bus.
- Contains a byte RAM plus a small memory-mapped I/O window: GPIO output and input, and a compare timer with an interrupt flag.
- Zero-wait-state reads, so the core needs no stall logic.

---
 rtl/bitos_data_mem_pkg.sv | 23 ++
 rtl/bitos_data_mem_if.sv | 10 +
 rtl/bitos_data_mem_timer.sv | 83 ++++++++
 rtl/bitos_data_mem.sv | 104 ++++++++++
 tb/tb_bitos_data_mem.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bitos_data_mem_pkg.sv
// Shared constants for the bitos_data_mem data-side memory stage:
// I/O window addresses, TIMER_CTRL bit layout and timer reset values.
package bitos_data_mem_pkg;

    localparam logic [7:0] ADDR_GPIO_OUT   = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN    = 8'hF1;
    localparam logic [7:0] ADDR_TIMER_CNT  = 8'hF2;
    localparam logic [7:0] ADDR_TIMER_CMP  = 8'hF3;
    localparam logic [7:0] ADDR_TIMER_CTRL = 8'hF4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_FLAG = 1;

    localparam logic [7:0] CMP_RST = 8'hFF;

    // Bit layout of TIMER_CTRL as seen on the read bus.
    typedef struct packed {
        logic [5:0] rsvd;
        logic       flag;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/bitos_data_mem_if.sv
// Core-to-data-memory bus: address, write strobe, write data and combinational read data.
interface bitos_data_mem_if;
    logic       i_W_R;
    logic [7:0] i_Address_Data_Bus;
    logic [7:0] i_Wr_Data;
    logic [7:0] o_Rd_Data;

    modport master (output i_W_R, output i_Address_Data_Bus, output i_Wr_Data, input o_Rd_Data);
    modport slave  (input i_W_R, input i_Address_Data_Bus, input i_Wr_Data, output o_Rd_Data);
endinterface

// File: rtl/bitos_data_mem_timer.sv
// bitos_timer: prescaled 8-bit compare timer with sticky, write-1-clear FLAG.
// Only instantiated when BITOS_TIMER_EN is defined.
module bitos_timer
    import bitos_data_mem_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic       sel_cmp_i,
    input  logic       sel_ctrl_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] cnt_o,
    output logic [7:0] cmp_o,
    output logic [7:0] ctrl_o,
    output logic       flag_o
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    cmp_q, cmp_d;
    logic          en_q, en_d;
    logic          flag_q, flag_d;
    logic          tick;
    ctrl_t         ctrl;

    always_comb begin
        psc_d  = psc_q;
        cnt_d  = cnt_q;
        cmp_d  = cmp_q;
        en_d   = en_q;
        flag_d = flag_q;
        tick   = 1'b0;
        if (en_q) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
                tick  = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
        if (wr_i && sel_cmp_i) cmp_d = wdata_i;
        if (wr_i && sel_ctrl_i) begin
            en_d = wdata_i[CTRL_EN];
            if (wdata_i[CTRL_FLAG]) flag_d = 1'b0;
        end
        // Tick compares against the CMP already in place, and its FLAG set overrides a clear.
        if (tick) begin
            if (cnt_q == cmp_q) begin
                cnt_d  = 8'h00;
                flag_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'h01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q  <= '0;
            cnt_q  <= 8'h00;
            cmp_q  <= CMP_RST;
            en_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            en_q   <= en_d;
            flag_q <= flag_d;
        end
    end

    assign ctrl   = '{rsvd: 6'd0, flag: flag_q, en: en_q};
    assign cnt_o  = cnt_q;
    assign cmp_o  = cmp_q;
    assign ctrl_o = ctrl;
    assign flag_o = flag_q;

endmodule

// File: rtl/bitos_data_mem.sv
// Zero-wait-state data memory for MicroBitos: byte RAM, GPIO and an optional compare
// timer (present only when macro BITOS_TIMER_EN is defined; otherwise o_irq is 0).
module bitos_data_mem
    import bitos_data_mem_pkg::*;
#(
    parameter int DEPTH       = 224,
    parameter int PRESCALE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    bitos_data_mem_if.slave   bus,
    input  logic [7:0]        i_gpio,
    output logic [7:0]        o_gpio,
    output logic              o_irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1 || DEPTH > 240 || PRESCALE < 1 || SYNC_STAGES < 1) begin : g_cfg_check
        $error("bitos_data_mem: illegal parameter set");
    end

    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic       ram_hit;
    logic [7:0] rd_data;

    assign addr    = bus.i_Address_Data_Bus;
    assign wdata   = bus.i_Wr_Data;
    assign wr      = bus.i_W_R;
    assign ram_hit = int'(addr) < DEPTH;

    // RAM has no reset; the write is gated so a write coinciding with reset is dropped.
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (wr && ram_hit && !reset) mem[addr[AW-1:0]] <= wdata;
    end

    logic [7:0] gpio_q;
    logic [7:0] gpio_d;
    assign gpio_d = (wr && addr == ADDR_GPIO_OUT) ? wdata : gpio_q;

    logic [7:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q <= 8'h00;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
        end else begin
            gpio_q    <= gpio_d;
            sync_q[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign o_gpio = gpio_q;

`ifdef BITOS_TIMER_EN
    logic [7:0] tmr_cnt;
    logic [7:0] tmr_cmp;
    logic [7:0] tmr_ctrl;
    logic       tmr_flag;

    bitos_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk        (clk),
        .rst        (reset),
        .wr_i       (wr),
        .sel_cmp_i  (addr == ADDR_TIMER_CMP),
        .sel_ctrl_i (addr == ADDR_TIMER_CTRL),
        .wdata_i    (wdata),
        .cnt_o      (tmr_cnt),
        .cmp_o      (tmr_cmp),
        .ctrl_o     (tmr_ctrl),
        .flag_o     (tmr_flag)
    );

    assign o_irq = tmr_flag;
`else
    assign o_irq = 1'b0;
`endif

    // Read path is purely combinational so the core never stalls.
    always_comb begin
        rd_data = 8'h00;
        if (ram_hit) begin
            rd_data = mem[addr[AW-1:0]];
        end else begin
            case (addr)
                ADDR_GPIO_OUT:   rd_data = gpio_q;
                ADDR_GPIO_IN:    rd_data = sync_q[SYNC_STAGES-1];
`ifdef BITOS_TIMER_EN
                ADDR_TIMER_CNT:  rd_data = tmr_cnt;
                ADDR_TIMER_CMP:  rd_data = tmr_cmp;
                ADDR_TIMER_CTRL: rd_data = tmr_ctrl;
`endif
                default:         rd_data = 8'h00;
            endcase
        end
    end

    assign bus.o_Rd_Data = rd_data;

endmodule

// File: tb/tb_bitos_data_mem.sv
// Bench for bitos_data_mem: directed scenarios plus random traffic checked against
// a behavioural memory-map model. Follows BITOS_TIMER_EN like the design does.
module tb_bitos_data_mem;
    import bitos_data_mem_pkg::*;

    localparam int DEPTH       = 224;
    localparam int PRESCALE    = 4;
    localparam int SYNC_STAGES = 2;
`ifdef BITOS_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_gpio = 8'h00;
    logic [7:0] o_gpio;
    logic       o_irq;

    bitos_data_mem_if bus();

    bitos_data_mem #(.DEPTH(DEPTH), .PRESCALE(PRESCALE), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .i_gpio (i_gpio),
        .o_gpio (o_gpio),
        .o_irq  (o_irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    // Behavioural model of the memory map.
    logic [7:0] m_ram   [256];
    bit         m_known [256];
    logic [7:0] m_gpio;
    logic [7:0] m_pins  [SYNC_STAGES];   // m_pins[k] = pin value k+1 edges ago
    logic [7:0] m_cnt, m_cmp;
    bit         m_en, m_flag;
    int         m_psc;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin : model
        bit tick, set_now, w;
        logic [7:0] a, d;
        if (reset) begin
            m_gpio = 8'h00;
            for (int i = 0; i < SYNC_STAGES; i++) m_pins[i] = 8'h00;
            m_cnt = 8'h00; m_cmp = 8'hFF; m_en = 1'b0; m_flag = 1'b0; m_psc = 0;
        end else begin
            w = bus.i_W_R; a = bus.i_Address_Data_Bus; d = bus.i_Wr_Data;
            tick = 1'b0; set_now = 1'b0;
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_pins[i] = m_pins[i-1];
            m_pins[0] = i_gpio;
            if (TIMER_ON && m_en) begin
                m_psc = m_psc + 1;
                if (m_psc == PRESCALE) begin m_psc = 0; tick = 1'b1; end
            end
            if (tick) begin
                if (m_cnt == m_cmp) begin m_cnt = 8'h00; set_now = 1'b1; end
                else m_cnt = m_cnt + 8'd1;
            end
            if (w) begin
                if (int'(a) < DEPTH) begin m_ram[a] = d; m_known[a] = 1'b1; end
                else if (a == ADDR_GPIO_OUT) m_gpio = d;
                else if (TIMER_ON && a == ADDR_TIMER_CMP) m_cmp = d;
                else if (TIMER_ON && a == ADDR_TIMER_CTRL) begin
                    m_en = d[0];
                    if (d[1]) m_flag = 1'b0;
                end
            end
            if (set_now) m_flag = 1'b1;
        end
    end

    function automatic bit exp_rd(input logic [7:0] a, output logic [7:0] v);
        v = 8'h00;
        if (int'(a) < DEPTH) begin
            v = m_ram[a];
            return m_known[a];
        end
        case (a)
            ADDR_GPIO_OUT:   v = m_gpio;
            ADDR_GPIO_IN:    v = m_pins[SYNC_STAGES-1];
            ADDR_TIMER_CNT:  v = TIMER_ON ? m_cnt : 8'h00;
            ADDR_TIMER_CMP:  v = TIMER_ON ? m_cmp : 8'h00;
            ADDR_TIMER_CTRL: v = TIMER_ON ? {6'd0, m_flag, m_en} : 8'h00;
            default:         v = 8'h00;
        endcase
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        logic [7:0] v;
        if (!done) begin
            check("gpio_out_pins", o_gpio, m_gpio);
            check("irq", {7'd0, o_irq}, {7'd0, m_flag});
            if (exp_rd(bus.i_Address_Data_Bus, v)) check("rd_data", bus.o_Rd_Data, v);
        end
    end

    task automatic cyc(input bit w, input logic [7:0] a, input logic [7:0] d);
        bus.i_W_R = w; bus.i_Address_Data_Bus = a; bus.i_Wr_Data = d;
        @(posedge clk); #1;
        bus.i_W_R = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] e);
        bus.i_W_R = 1'b0; bus.i_Address_Data_Bus = a;
        #1;
        check(name, bus.o_Rd_Data, e);
    endtask

    initial begin
        bus.i_W_R = 1'b0; bus.i_Address_Data_Bus = 8'hF0; bus.i_Wr_Data = 8'h00;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        rd_check("rst_gpio_out", ADDR_GPIO_OUT, 8'h00);
        rd_check("rst_cnt", ADDR_TIMER_CNT, 8'h00);
`ifdef BITOS_TIMER_EN
        rd_check("rst_cmp", ADDR_TIMER_CMP, 8'hFF);
`else
        rd_check("rst_cmp_unmapped", ADDR_TIMER_CMP, 8'h00);
`endif
        rd_check("rst_ctrl", ADDR_TIMER_CTRL, 8'h00);
        check("rst_irq", {7'd0, o_irq}, 8'h00);
        check("rst_gpio_pins", o_gpio, 8'h00);

        cyc(1'b1, 8'h10, 8'h04);
        cyc(1'b1, 8'hDF, 8'hA5);
        rd_check("ram_10", 8'h10, 8'h04);
        rd_check("ram_df", 8'hDF, 8'hA5);
        cyc(1'b1, 8'hE5, 8'h5A);
        rd_check("unmapped_e5", 8'hE5, 8'h00);
        bus.i_W_R = 1'b1; bus.i_Address_Data_Bus = 8'h10; bus.i_Wr_Data = 8'h77;
        #1 check("rd_during_wr", bus.o_Rd_Data, 8'h04);
        @(posedge clk); #1;
        rd_check("rd_after_wr", 8'h10, 8'h77);

        cyc(1'b1, ADDR_GPIO_OUT, 8'h3C);
        check("gpio_out_3c", o_gpio, 8'h3C);
        i_gpio = 8'h81;
        cyc(1'b0, ADDR_GPIO_IN, 8'h00);
        rd_check("gpio_in_1clk", ADDR_GPIO_IN, 8'h00);
        cyc(1'b0, ADDR_GPIO_IN, 8'h00);
        rd_check("gpio_in_2clk", ADDR_GPIO_IN, 8'h81);
        cyc(1'b1, ADDR_GPIO_IN, 8'h55);
        rd_check("gpio_in_ro", ADDR_GPIO_IN, 8'h81);

`ifdef BITOS_TIMER_EN
        cyc(1'b1, ADDR_TIMER_CMP, 8'h03);
        cyc(1'b1, ADDR_TIMER_CTRL, 8'h01);
        repeat (15) cyc(1'b0, ADDR_TIMER_CNT, 8'h00);
        rd_check("cnt_3", ADDR_TIMER_CNT, 8'h03);
        check("irq_before_match", {7'd0, o_irq}, 8'h00);
        cyc(1'b0, ADDR_TIMER_CNT, 8'h00);
        rd_check("cnt_wrap", ADDR_TIMER_CNT, 8'h00);
        rd_check("ctrl_flag_set", ADDR_TIMER_CTRL, 8'h03);
        check("irq_set", {7'd0, o_irq}, 8'h01);
        cyc(1'b1, ADDR_TIMER_CTRL, 8'h03);
        rd_check("ctrl_cleared", ADDR_TIMER_CTRL, 8'h01);
        check("irq_cleared", {7'd0, o_irq}, 8'h00);
        cyc(1'b1, ADDR_TIMER_CMP, 8'h00);
        cyc(1'b0, ADDR_TIMER_CNT, 8'h00);
        cyc(1'b1, ADDR_TIMER_CTRL, 8'h03);
        rd_check("set_beats_clear", ADDR_TIMER_CTRL, 8'h03);
        check("irq_set_beats_clear", {7'd0, o_irq}, 8'h01);
`else
        cyc(1'b1, ADDR_TIMER_CMP, 8'h12);
        rd_check("cmp_unmapped", ADDR_TIMER_CMP, 8'h00);
        cyc(1'b1, ADDR_TIMER_CTRL, 8'h01);
        repeat (12) cyc(1'b0, ADDR_TIMER_CNT, 8'h00);
        rd_check("cnt_unmapped", ADDR_TIMER_CNT, 8'h00);
        check("irq_tied_low", {7'd0, o_irq}, 8'h00);
`endif

        #1 reset = 1'b1;
        #1 check("async_irq", {7'd0, o_irq}, 8'h00);
        check("async_gpio", o_gpio, 8'h00);
        rd_check("async_cnt", ADDR_TIMER_CNT, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rd_check("ram_keep_10", 8'h10, 8'h77);
        rd_check("ram_keep_df", 8'hDF, 8'hA5);

        repeat (3000) begin
            logic [7:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 8'($urandom_range(0, DEPTH - 1));
                4:          a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'hE0, 8'hEF))
                                                            : 8'($urandom_range(8'hF5, 8'hFF));
                default:    a = 8'($urandom_range(8'hF0, 8'hF4));
            endcase
            bus.i_W_R = 1'($urandom_range(0, 1));
            bus.i_Address_Data_Bus = a;
            bus.i_Wr_Data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) i_gpio = 8'($urandom);
            @(posedge clk); #1;
        end

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
